// File: rtl/io_bus_slave_if.sv
// Internal 32-bit IO bus: four-phase request/acknowledge handshake with
// separate write (data_out) and read (data_in) data paths.
interface IO_bus;
    logic        handshake1_1;
    logic        handshake1_2;
    logic        RW;
    logic [7:0]  reg_address;
    logic [31:0] data_out;
    logic [31:0] data_in;

    modport master (
        output handshake1_1,
        output RW,
        output reg_address,
        output data_out,
        input  handshake1_2,
        input  data_in
    );

    modport slave (
        input  handshake1_1,
        input  RW,
        input  reg_address,
        input  data_out,
        output handshake1_2,
        output data_in
    );
endinterface

// File: rtl/io_bus_slave.sv
// IO bus slave: NOS_REGS read/write config registers followed by one
// read-only status word, starting at BASE_ADDR.
//
// state   | meaning
// IDLE    | waiting for a request strobe
// ACCESS  | selected request: perform write or load read data
// ACK     | acknowledge asserted, read data held until strobe drops
// RELEASE | acknowledge and read data dropped, back to IDLE next
// IGNORE  | request not for this slave, wait for strobe to drop
module io_bus_slave #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int          NOS_REGS  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    IO_bus.slave                     bus,
    output logic [32*NOS_REGS-1:0]   config_out,
    output logic [NOS_REGS-1:0]      reg_wr_strobe,
    input  logic [31:0]              status_in
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        ACK     = 3'd2,
        RELEASE = 3'd3,
        IGNORE  = 3'd4
    } state_t;

    localparam logic [8:0] NOS_W = 9'(NOS_REGS);

    state_t state;
    state_t state_nxt;

    logic [31:0]          cfg_regs [NOS_REGS];
    logic                 ack_q;
    logic [31:0]          rdata_q;
    logic [NOS_REGS-1:0]  wr_en;
    logic [31:0]          rd_mux;

    // Decode in 9 bits so BASE_ADDR near the top of the map cannot wrap.
    logic [8:0] addr_ext;
    logic [8:0] base_ext;
    logic [8:0] offset;
    logic       at_or_above_base;
    logic       hit_cfg;
    logic       hit_status;
    logic       selected;

    assign addr_ext         = {1'b0, bus.reg_address};
    assign base_ext         = {1'b0, BASE_ADDR};
    assign offset           = addr_ext - base_ext;
    assign at_or_above_base = (addr_ext >= base_ext);
    assign hit_cfg          = at_or_above_base && (offset < NOS_W);
    assign hit_status       = at_or_above_base && (offset == NOS_W);
    assign selected         = hit_cfg || hit_status;

    always_comb begin
        rd_mux = status_in;
        for (int k = 0; k < NOS_REGS; k++) begin
            if (hit_cfg && (offset == 9'(k))) begin
                rd_mux = cfg_regs[k];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = '0;
        case (state)
            IDLE: begin
                if (bus.handshake1_1) begin
                    state_nxt = selected ? ACCESS : IGNORE;
                end
            end
            ACCESS: begin
                // Completes even if the master already dropped its strobe.
                state_nxt = ACK;
                if (!bus.RW && hit_cfg) begin
                    for (int k = 0; k < NOS_REGS; k++) begin
                        wr_en[k] = (offset == 9'(k));
                    end
                end
            end
            ACK: begin
                if (!bus.handshake1_1) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            IGNORE: begin
                if (!bus.handshake1_1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            for (int k = 0; k < NOS_REGS; k++) begin
                cfg_regs[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            ack_q <= (state_nxt == ACK);
            // Read data is only non-zero while acknowledging; the bus ORs slaves.
            if (state_nxt == ACK) begin
                if (state == ACCESS) begin
                    rdata_q <= bus.RW ? rd_mux : 32'h0;
                end
            end else begin
                rdata_q <= '0;
            end
            for (int k = 0; k < NOS_REGS; k++) begin
                if (wr_en[k]) begin
                    cfg_regs[k] <= bus.data_out;
                end
            end
        end
    end

    assign bus.handshake1_2 = ack_q;
    assign bus.data_in      = rdata_q;
    assign reg_wr_strobe    = reset ? wr_en : '0;

    for (genvar g = 0; g < NOS_REGS; g++) begin : g_cfg_out
        assign config_out[32*g +: 32] = cfg_regs[g];
    end

endmodule

// File: tb/tb_io_bus_slave.sv
// Directed bench for io_bus_slave: expected read data queued at request time,
// compared when the acknowledge appears; a register model tracks config writes.
module tb_io_bus_slave;

    localparam logic [7:0] BASE = 8'h10;
    localparam int         NREG = 4;

    logic             clk;
    logic             reset;
    logic [127:0]     config_out;
    logic [3:0]       reg_wr_strobe;
    logic [31:0]      status_in;

    IO_bus bus_if();

    io_bus_slave #(.BASE_ADDR(BASE), .NOS_REGS(NREG)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .config_out    (config_out),
        .reg_wr_strobe (reg_wr_strobe),
        .status_in     (status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_cfg [NREG];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int k = 0; k < NREG; k++) f[32*k +: 32] = model_cfg[k];
        return f;
    endfunction

    // Called at a negedge in IDLE. Strobe is sampled high on `hold` edges.
    task automatic txn(input string tag, input logic [7:0] a, input logic rw,
                       input logic [31:0] wd, input int hold);
        logic        sel_cfg, sel_st, sel;
        logic [3:0]  exp_strobe;
        int          strobes, ack_cycles, first_ack, exp_ack;
        logic        data_leak;
        logic [31:0] exp_rd;
        sel_cfg    = (a >= BASE) && (a < BASE + 8'(NREG));
        sel_st     = (a == BASE + 8'(NREG));
        sel        = sel_cfg || sel_st;
        exp_strobe = (sel_cfg && !rw) ? (4'b0001 << (a - BASE)) : 4'b0000;
        exp_rd     = sel_cfg ? model_cfg[a - BASE] : status_in;
        if (sel) exp_q.push_back(rw ? exp_rd : 32'h0);
        if (sel_cfg && !rw) model_cfg[a - BASE] = wd;
        exp_ack    = !sel ? 0 : (hold > 1 ? hold - 1 : 1);

        bus_if.reg_address  = a;
        bus_if.RW           = rw;
        bus_if.data_out     = wd;
        bus_if.handshake1_1 = 1'b1;
        strobes    = 0;
        ack_cycles = 0;
        first_ack  = -1;
        data_leak  = 1'b0;
        for (int c = 1; c <= hold + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            strobes += $countones(reg_wr_strobe);
            if (c == 1) chk({tag, ":strobe"}, 128'(reg_wr_strobe), 128'(exp_strobe));
            if (bus_if.handshake1_2) begin
                ack_cycles++;
                if (first_ack < 0) begin
                    first_ack = c;
                    if (exp_q.size() > 0) chk({tag, ":rdata"}, 128'(bus_if.data_in), 128'(exp_q.pop_front()));
                    else chk({tag, ":unexpected_ack"}, 128'(1), 128'(0));
                end
            end else if (bus_if.data_in !== 32'h0) begin
                data_leak = 1'b1;
            end
            if (c == 2) begin
                // Changes after the access must not matter.
                bus_if.reg_address = BASE;
                bus_if.data_out    = 32'hBADBAD00;
                bus_if.RW          = ~rw;
                status_in          = status_in ^ 32'hFFFF0000;
            end
            if (c == hold) bus_if.handshake1_1 = 1'b0;
        end
        chk({tag, ":ack_cycles"}, 128'(ack_cycles), 128'(exp_ack));
        if (sel) chk({tag, ":ack_latency"}, 128'(first_ack), 128'(2));
        chk({tag, ":strobe_count"}, 128'(strobes), 128'(exp_strobe != 0 ? 1 : 0));
        chk({tag, ":data_idle_zero"}, 128'(data_leak), 128'(0));
        chk({tag, ":config"}, config_out, model_flat());
        if (exp_q.size() != 0) begin
            chk({tag, ":no_ack_timeout"}, 128'(exp_q.size()), 128'(0));
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NREG; k++) model_cfg[k] = 32'h0;
        reset               = 1'b0;
        status_in           = 32'h0;
        bus_if.handshake1_1 = 1'b0;
        bus_if.RW           = 1'b0;
        bus_if.reg_address  = 8'h00;
        bus_if.data_out     = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset:ack", 128'(bus_if.handshake1_2), 128'(0));
        chk("reset:data_in", 128'(bus_if.data_in), 128'(0));
        chk("reset:config", config_out, 128'(0));
        chk("reset:strobe", 128'(reg_wr_strobe), 128'(0));
        reset = 1'b1;
        @(negedge clk);

        txn("write_r2", 8'h12, 1'b0, 32'hDEADBEEF, 3);
        status_in = 32'h0000A5A5;
        txn("read_status", 8'h14, 1'b1, 32'h0, 3);
        txn("read_r2", 8'h12, 1'b1, 32'h0, 2);
        txn("unselected_hi", 8'h20, 1'b0, 32'h11111111, 4);
        txn("unselected_lo", 8'h0F, 1'b1, 32'h0, 2);
        txn("write_status", 8'h14, 1'b0, 32'h12345678, 2);
        txn("write_r0", 8'h10, 1'b0, 32'h01020304, 2);
        txn("write_r3", 8'h13, 1'b0, 32'hCAFEF00D, 3);
        txn("read_r3", 8'h13, 1'b1, 32'h0, 2);
        txn("slow_write_r1", 8'h11, 1'b0, 32'h55AA55AA, 10);
        txn("short_strobe_w0", 8'h10, 1'b0, 32'h0BADC0DE, 1);
        txn("read_r1", 8'h11, 1'b1, 32'h0, 2);

        // Reset while acknowledging a write to reg 0.
        bus_if.reg_address  = 8'h10;
        bus_if.RW           = 1'b0;
        bus_if.data_out     = 32'h77778888;
        bus_if.handshake1_1 = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_in_ack:ack_before", 128'(bus_if.handshake1_2), 128'(1));
        chk("rst_in_ack:r0_written", 128'(config_out[31:0]), 128'(32'h77778888));
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ack:ack_after", 128'(bus_if.handshake1_2), 128'(0));
        chk("rst_in_ack:config", config_out, 128'(0));
        chk("rst_in_ack:data_in", 128'(bus_if.data_in), 128'(0));
        for (int k = 0; k < NREG; k++) model_cfg[k] = 32'h0;
        bus_if.handshake1_1 = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("post_reset:idle_no_ack", 128'(bus_if.handshake1_2), 128'(0));
        txn("post_reset_write_r1", 8'h11, 1'b0, 32'hA0B0C0D0, 2);
        txn("post_reset_read_r1", 8'h11, 1'b1, 32'h0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bus_slave.md
IO_BUS_SLAVE -- requirements
Module: io_bus_slave

Parameters
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'h00, meaning the first bus register address owned by this slave.
REQ-002 The block SHALL have parameter NOS_REGS, default 4, meaning the number of 32-bit read/write config registers (1..8).

Interface
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-005 The block SHALL have port bus, IO_bus.slave modport, the internal 32-bit bus, with the members listed in REQ-006 to REQ-011.
REQ-006 The bus SHALL include handshake1_1, input, 1, master request strobe.
REQ-007 The bus SHALL include handshake1_2, output, 1, slave acknowledge.
REQ-008 The bus SHALL include RW, input, 1, access direction: 1 = read from slave, 0 = write to slave.
REQ-009 The bus SHALL include reg_address, input, 8, register address.
REQ-010 The bus SHALL include data_out, input, 32, write data from the master.
REQ-011 The bus SHALL include data_in, output, 32, read data to the master; the top level ORs all slaves' data_in.
REQ-012 The block SHALL have port config_out, output, 32*NOS_REGS, the config register contents, with reg k at bits [32k+31:32k].
REQ-013 The block SHALL have port reg_wr_strobe, output, NOS_REGS, a one-cycle pulse per config register when it is written.
REQ-014 The block SHALL have port status_in, input, 32, the read-only subsystem status, sampled at the access cycle.

Function
REQ-015 The address map SHALL be:
- BASE_ADDR+k (k < NOS_REGS): config reg k, read/write.
- BASE_ADDR+NOS_REGS: status, read-only.
- All other addresses are not selected.
REQ-016 The FSM SHALL have states IDLE, ACCESS, ACK, RELEASE and IGNORE.
REQ-017 From IDLE, when handshake1_1=1 and the address is selected, the FSM SHALL go to ACCESS; when handshake1_1=1 and the address is not selected, it SHALL go to IGNORE; otherwise it SHALL stay in IDLE.
REQ-018 In ACCESS the block SHALL, for a write (RW=0) to config reg k, load data_out into reg k and pulse reg_wr_strobe[k] for this single cycle.
REQ-019 In ACCESS the block SHALL, for a read (RW=1), register the addressed value (config reg k or status_in) into data_in.
REQ-020 A write to the status address SHALL change no state, SHALL pulse no strobe, and SHALL still be acknowledged.
REQ-021 From ACCESS the FSM SHALL go to ACK unconditionally.
REQ-022 In ACK, handshake1_2 SHALL be 1 and data_in SHALL be held; the FSM SHALL stay in ACK while handshake1_1=1 and go to RELEASE when handshake1_1=0.
REQ-023 In RELEASE, handshake1_2 SHALL be 0 and data_in SHALL be 32'h0; the FSM SHALL then go to IDLE.
REQ-024 In IGNORE, handshake1_2 SHALL be 0 and data_in SHALL be 0; the FSM SHALL return to IDLE once handshake1_1=0.
REQ-025 Latency: with handshake1_1 sampled high at edge N, ACCESS SHALL be entered at edge N, and handshake1_2 and valid data_in SHALL be present after edge N+1.
REQ-026 handshake1_2 SHALL deassert on the edge following the sample of handshake1_1=0 in ACK.
REQ-027 handshake1_2 and data_in SHALL be registered outputs.
REQ-028 data_in SHALL be 0 in every state except ACK (and the load in ACCESS), so that the OR-combined bus is never corrupted.
REQ-029 reg_address, RW and data_out SHALL be captured once, in ACCESS; changes to them during ACK SHALL have no effect.
REQ-030 If handshake1_1 falls during ACCESS (protocol violation), the access SHALL still complete, ACK SHALL last one cycle, and the FSM SHALL then go to RELEASE.
REQ-031 A new request SHALL be accepted only from IDLE; at least one IDLE cycle SHALL separate back-to-back transactions.

Reset
REQ-032 On reset=0 at a clock edge, the FSM SHALL go to IDLE, handshake1_2=0, data_in=0, all config regs=0 and reg_wr_strobe=0, in any state.
REQ-033 A reset during ACK SHALL drop handshake1_2 on that edge; after reset the block SHALL stay in IDLE until handshake1_1=1 is sampled.

Verification
REQ-034 Write test: BASE_ADDR=8'h10, write 32'hDEADBEEF to 8'h12 -> config reg 2 = DEADBEEF, reg_wr_strobe=4'b0100 for 1 cycle, handshake1_2 high 2 cycles after request.
REQ-035 Read test: status_in=32'h0000A5A5, read 8'h14 -> data_in=0000A5A5 while handshake1_2=1, then 0 after release.
REQ-036 Unselected test: request to 8'h20 -> handshake1_2 never asserts, data_in stays 0, FSM returns to IDLE after handshake1_1 falls.
REQ-037 Status write test: write 32'h12345678 to 8'h14 -> acknowledged, no strobe, config regs unchanged.
REQ-038 Reset test: assert reset while in ACK after writing reg 0 -> handshake1_2=0 next edge, config_out all 0, next transaction completes normally.
REQ-039 Slow master test: hold handshake1_1 high 10 cycles -> handshake1_2 stays high throughout, and exactly one write strobe is generated.
